// File: rtl/apb3_pkg.sv
// Shared types and constants for the APB3 register slave.
package apb3_pkg;

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam int unsigned CNT_W           = 4;
   localparam int unsigned DEF_ADDR_W      = 8;
   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_NUM_REGS    = 8;
   localparam int unsigned DEF_WAIT_CYCLES = 0;

endpackage

// File: rtl/apb3_wait_timer.sv
// Wait-state down-counter: loads on setup phase, decrements to zero, flags zero.
module apb3_wait_timer
   import apb3_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/apb3_reg_slave.sv
// APB3 register-file slave with configurable wait states and read-only mask.
// Define APB3_SLV_PSLVERR_EN to report out-of-range and read-only-write errors on pslverr.
module apb3_reg_slave
   import apb3_pkg::*;
#(
   parameter int unsigned          ADDR_W      = DEF_ADDR_W,
   parameter int unsigned          DATA_W      = DEF_DATA_W,
   parameter int unsigned          NUM_REGS    = DEF_NUM_REGS,
   parameter int unsigned          WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
   parameter logic [DATA_W-1:0]    RESET_VAL   = '0
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [ADDR_W-1:0] paddr,
   input  logic [DATA_W-1:0] pwdata,
   output logic              pready,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr
);

   localparam int unsigned IDX_W = ADDR_W - 2;
   localparam int unsigned SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   state_t              state, state_nxt;
   logic                cnt_load, cnt_dec, cnt_zero;
   logic                complete, in_range, wr_commit;
   logic [IDX_W-1:0]    idx;
   logic [31:0]         idx_ext;
   logic [SEL_W-1:0]    sel;
   logic [DATA_W-1:0]   rd_val;
   logic [NUM_REGS-1:0] wr_hit;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic                unused_addr_lsb;

   assign idx             = paddr[ADDR_W-1:2];
   assign idx_ext         = 32'(idx);
   assign sel             = idx[SEL_W-1:0];
   assign in_range        = (idx_ext < NUM_REGS);
   assign unused_addr_lsb = ^paddr[1:0];

   apb3_wait_timer u_timer (
      .clk      (pclk),
      .rst_n    (presetn),
      .load     (cnt_load),
      .load_val (CNT_W'(WAIT_CYCLES)),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge pclk) begin
      if (!presetn) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         IDLE: begin
            if (psel && !penable) begin
               state_nxt = ACCESS;
               cnt_load  = 1'b1;
            end
         end
         ACCESS: begin
            // Deselect before completion aborts; a repeated setup phase restarts the wait.
            if (!psel) begin
               state_nxt = IDLE;
            end else if (!penable) begin
               cnt_load = 1'b1;
            end else if (cnt_zero) begin
               state_nxt = IDLE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign complete  = (state == ACCESS) && psel && penable && cnt_zero;
   assign pready    = complete;
   assign wr_commit = complete && pwrite && in_range;

   always_comb begin
      wr_hit = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         wr_hit[i] = wr_commit && (idx_ext == i) && !RO_MASK[i];
      end
   end

   always_ff @(posedge pclk) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (!presetn)       regs[i] <= RESET_VAL;
         else if (wr_hit[i]) regs[i] <= pwdata;
      end
   end

   assign rd_val = in_range ? regs[sel] : '0;
   assign prdata = (complete && !pwrite) ? rd_val : '0;

`ifdef APB3_SLV_PSLVERR_EN
   assign pslverr = complete && (!in_range || (pwrite && RO_MASK[sel]));
`else
   assign pslverr = 1'b0;
`endif

endmodule
